acortex_cfg_seqr: RTL
=====================

Name: acortex_cfg_seqr

Overview:
- Local-bus master that brings up the audio path after reset or on software request.
- Programs a table of SSM2603 codec registers over I2C, one register at a time:
  - writes the I2C master's data and control registers;
  - polls its status until the transfer completes.
- Then writes the driver-enable register.
- Sits beside the Audio Cortex top and drives its local-bus slave port (I2C master, SSM2603 driver), so the codec comes up without CPU sequencing.

Parameters:
- LB_DATA_W, 32, local bus data width
- LB_ADDR_W, 12, local bus address width
- NUM_REGS, 10, codec register writes in the table
- I2C_DEV_ADDR, 8'h34, SSM2603 I2C write address byte
- I2C_DATA_ADDR, 12'h010, LB address of I2C master data register
- I2C_CTRL_ADDR, 12'h000, LB address of I2C master control register
- I2C_STAT_ADDR, 12'h004, LB address of I2C master status register
- I2C_START_VAL, 32'h0000_0031, control write: start, 3 bytes, write mode
- DRVR_EN_ADDR, 12'h100, LB address of driver control register
- DRVR_EN_VAL, 32'h0000_0001, value enabling the driver
- POLL_GAP, 16, idle cycles between status reads
- TIMEOUT_W, 16, poll timeout counter width

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse: begin sequence (ignored unless IDLE, DONE or ERR)
- cfg_table  in  NUM_REGS*16  entry i = bits [16i+15:16i] = {7b reg addr, 9b data}; entry 0 first
- busy  out  1  sequence in progress
- done  out  1  sticky: sequence completed OK; cleared on start
- err  out  1  sticky: NACK or timeout; cleared on start
- err_idx  out  $clog2(NUM_REGS)  table index active when err set
- lb_wr_en  out  1  LB write strobe, single cycle
- lb_rd_en  out  1  LB read strobe, single cycle
- lb_addr  out  LB_ADDR_W  LB address
- lb_wr_data  out  LB_DATA_W  LB write data
- lb_wr_valid  in  1  write acknowledge
- lb_rd_valid  in  1  read data valid
- lb_rd_data  in  LB_DATA_W  read data; bit0 = I2C busy, bit1 = NACK

Behaviour:
- Reset: all outputs 0; FSM in IDLE; index 0; counters 0.
- LB rule: exactly one outstanding access.
  - A strobe is high for one cycle with addr/data stable from the strobe until its valid.
  - Addr/data hold their last values otherwise.
  - No new strobe until the matching valid arrives.
  - Valid in the same cycle as the strobe is not possible; earliest acknowledge is the cycle after the strobe.
- States and transitions:
  - IDLE: start -> WR_DATA; busy=1; done, err cleared.
  - WR_DATA: strobe write to I2C_DATA_ADDR with {8'h00, I2C_DEV_ADDR, entry[15:8], entry[7:0]} -> W_DATA.
  - W_DATA: on lb_wr_valid -> WR_CTRL.
  - WR_CTRL: strobe write to I2C_CTRL_ADDR with I2C_START_VAL -> W_CTRL.
  - W_CTRL: on lb_wr_valid -> GAP.
  - GAP: count POLL_GAP cycles -> RD_STAT.
  - RD_STAT: strobe read to I2C_STAT_ADDR -> W_STAT.
  - W_STAT: on lb_rd_valid:
    - bit1=1 -> ERR;
    - else bit0=1 -> GAP;
    - else index==NUM_REGS-1 -> WR_EN;
    - else index++ -> WR_DATA.
  - WR_EN: strobe write to DRVR_EN_ADDR with DRVR_EN_VAL -> W_EN.
  - W_EN: on lb_wr_valid -> DONE.
  - DONE: done=1, busy=0. start -> WR_DATA with index reset to 0.
  - ERR: err=1, busy=0, err_idx=index. start -> WR_DATA with index reset to 0.
- Timeout:
  - Counter cleared on entering WR_DATA; increments every cycle in states WR_DATA..W_STAT.
  - At all-ones it forces ERR from any of those states; an outstanding access is abandoned (no further strobe issued).
  - Same counter is used in WR_EN/W_EN.
- start while busy: ignored.
- Simultaneous NACK and busy bits: NACK wins (ERR).
- NUM_REGS=1: after the first successful poll, go directly to WR_EN.
- rst_n low mid-sequence: immediate return to reset values; no further LB strobes; no partial completion reported.
- Minimum latency per entry at zero-wait LB (valid one cycle after strobe, status idle on first read): 2 + 2 + POLL_GAP + 2 cycles.

Test Plan:
- NUM_REGS=2, table {16'h1E00, 16'h0C10}, zero-wait slave, status 0 -> write sequence:
  - 0x010=0x00341E00, 0x000=0x31, read 0x004;
  - 0x010=0x00340C10, 0x000=0x31, read 0x004;
  - 0x100=0x1;
  - then done=1, busy=0.
- Status returns bit0=1 three times then 0 -> exactly 4 status reads for that entry, each preceded by 16 idle cycles; sequence completes.
- Entry 1 status returns 0x2 -> err=1, err_idx=1, done=0; no write to 0x100.
- Slave never asserts lb_wr_valid on the control write -> err after 2^16-1 cycles, no further strobes; start then reruns from entry 0.
- rst_n pulsed while in W_STAT -> all outputs 0 on next cycle; start afterwards gives a clean full sequence.
- Random wait states 0-20 cycles on every access -> never more than one outstanding strobe, addr/data stable until valid, final LB transaction log matches the zero-wait case.

Source files
------------

// File: rtl/acortex_cfg_seqr_if.sv
// Local-bus port between the codec bring-up sequencer (master) and the
// Audio Cortex local-bus slave (I2C master, SSM2603 driver).
//
// Handshake: the master raises lb_wr_en or lb_rd_en for exactly one cycle,
// with lb_addr/lb_wr_data valid in that cycle. Both stay stable until the
// slave answers with lb_wr_valid (write) or lb_rd_valid plus lb_rd_data
// (read), one or more cycles after the strobe. Only one access is ever
// outstanding; the master issues no new strobe before the answer arrives.
interface acortex_cfg_seqr_if #(
  parameter int LB_DATA_W = 32,
  parameter int LB_ADDR_W = 12
) ();
  logic                 lb_wr_en;
  logic                 lb_rd_en;
  logic [LB_ADDR_W-1:0] lb_addr;
  logic [LB_DATA_W-1:0] lb_wr_data;
  logic                 lb_wr_valid;
  logic                 lb_rd_valid;
  logic [LB_DATA_W-1:0] lb_rd_data;

  modport master (
    output lb_wr_en, lb_rd_en, lb_addr, lb_wr_data,
    input  lb_wr_valid, lb_rd_valid, lb_rd_data
  );

  modport slave (
    input  lb_wr_en, lb_rd_en, lb_addr, lb_wr_data,
    output lb_wr_valid, lb_rd_valid, lb_rd_data
  );
endinterface

// File: rtl/acortex_cfg_seqr.sv
// Codec bring-up sequencer: walks a table of SSM2603 register writes,
// pushing each one through the I2C master over the local bus and polling
// its status, then enables the SSM2603 driver. A single timeout counter
// guards every entry and the final driver-enable write.
module acortex_cfg_seqr #(
  parameter int                LB_DATA_W     = 32,
  parameter int                LB_ADDR_W     = 12,
  parameter int                NUM_REGS      = 10,
  parameter logic [7:0]        I2C_DEV_ADDR  = 8'h34,
  parameter logic [11:0]       I2C_DATA_ADDR = 12'h010,
  parameter logic [11:0]       I2C_CTRL_ADDR = 12'h000,
  parameter logic [11:0]       I2C_STAT_ADDR = 12'h004,
  parameter logic [31:0]       I2C_START_VAL = 32'h0000_0031,
  parameter logic [11:0]       DRVR_EN_ADDR  = 12'h100,
  parameter logic [31:0]       DRVR_EN_VAL   = 32'h0000_0001,
  parameter int                POLL_GAP      = 16,
  parameter int                TIMEOUT_W     = 16,
  localparam int               IDX_W         = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [NUM_REGS*16-1:0] cfg_table,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [IDX_W-1:0]      err_idx,
  output logic [3:0]            dbg_state,
  acortex_cfg_seqr_if.master    lb
);

  localparam int GAP_W = $clog2(POLL_GAP) + 1;

  typedef enum logic [3:0] {
    S_IDLE, S_WR_DATA, S_W_DATA, S_WR_CTRL, S_W_CTRL, S_GAP,
    S_RD_STAT, S_W_STAT, S_WR_EN, S_W_EN, S_DONE, S_ERR
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [TIMEOUT_W-1:0] tmo_q;
  logic [GAP_W-1:0]     gap_q;
  logic [LB_ADDR_W-1:0] addr_q, addr_c;
  logic [LB_DATA_W-1:0] data_q, data_c;
  logic                 wr_c, rd_c;
  logic                 tmo_active, tmo_hit;
  logic [15:0]          entry;

  // The timeout runs only while an entry or the driver-enable is in flight.
  assign tmo_active = (state_q inside {S_WR_DATA, S_W_DATA, S_WR_CTRL, S_W_CTRL,
                                       S_GAP, S_RD_STAT, S_W_STAT, S_WR_EN, S_W_EN});
  assign tmo_hit    = tmo_active && (tmo_q == '1);
  assign entry      = cfg_table[idx_q*16 +: 16];

  // Next-state and bus strobes; addr/data hold their last value unless a strobe issues.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wr_c    = 1'b0;
    rd_c    = 1'b0;
    addr_c  = addr_q;
    data_c  = data_q;
    if (tmo_hit) begin
      // Abandon any outstanding access; the gated strobes stay low.
      state_d = S_ERR;
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state_d = S_WR_DATA;
            idx_d   = '0;
          end
        end
        S_WR_DATA: begin
          wr_c    = 1'b1;
          addr_c  = LB_ADDR_W'(I2C_DATA_ADDR);
          data_c  = LB_DATA_W'({8'h00, I2C_DEV_ADDR, entry});
          state_d = S_W_DATA;
        end
        S_W_DATA: if (lb.lb_wr_valid) state_d = S_WR_CTRL;
        S_WR_CTRL: begin
          wr_c    = 1'b1;
          addr_c  = LB_ADDR_W'(I2C_CTRL_ADDR);
          data_c  = LB_DATA_W'(I2C_START_VAL);
          state_d = S_W_CTRL;
        end
        S_W_CTRL: if (lb.lb_wr_valid) state_d = S_GAP;
        S_GAP: if (gap_q == GAP_W'(POLL_GAP - 1)) state_d = S_RD_STAT;
        S_RD_STAT: begin
          rd_c    = 1'b1;
          addr_c  = LB_ADDR_W'(I2C_STAT_ADDR);
          state_d = S_W_STAT;
        end
        S_W_STAT: begin
          if (lb.lb_rd_valid) begin
            // NACK outranks the busy bit.
            if (lb.lb_rd_data[1])                      state_d = S_ERR;
            else if (lb.lb_rd_data[0])                 state_d = S_GAP;
            else if (idx_q == IDX_W'(NUM_REGS - 1))    state_d = S_WR_EN;
            else begin
              idx_d   = idx_q + 1'b1;
              state_d = S_WR_DATA;
            end
          end
        end
        S_WR_EN: begin
          wr_c    = 1'b1;
          addr_c  = LB_ADDR_W'(DRVR_EN_ADDR);
          data_c  = LB_DATA_W'(DRVR_EN_VAL);
          state_d = S_W_EN;
        end
        S_W_EN: if (lb.lb_wr_valid) state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FSM state and table index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Timeout restarts at each entry and at the driver-enable; gap counter runs only in GAP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= '0;
      gap_q <= '0;
    end else begin
      if (state_d == S_WR_DATA || state_d == S_WR_EN) tmo_q <= '0;
      else if (tmo_active)                            tmo_q <= tmo_q + 1'b1;
      if (state_q == S_GAP) gap_q <= gap_q + 1'b1;
      else                  gap_q <= '0;
    end
  end

  // Hold registers keep the bus address/data stable between strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      data_q <= '0;
    end else begin
      addr_q <= addr_c;
      data_q <= data_c;
    end
  end

  assign lb.lb_wr_en   = wr_c;
  assign lb.lb_rd_en   = rd_c;
  assign lb.lb_addr    = addr_c;
  assign lb.lb_wr_data = data_c;

  assign busy      = !(state_q inside {S_IDLE, S_DONE, S_ERR});
  assign done      = (state_q == S_DONE);
  assign err       = (state_q == S_ERR);
  assign err_idx   = err ? idx_q : '0;
  assign dbg_state = state_q;

endmodule
